// File: rtl/wb_scheduler_pkg.sv
// Shared constants for the writeback path: register-file geometry and data width.
package wb_scheduler_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
endpackage

// File: rtl/wb_scheduler_rr_arbiter.sv
// Round-robin selector: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant
);

   logic             w_found;
   logic [PTR_W:0]   w_sum;
   logic [PTR_W-1:0] w_idx;

   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      // Walk the requesters starting at the pointer, wrapping modulo N.
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
         if (w_sum >= (PTR_W+1)'(N))
            w_sum = w_sum - (PTR_W+1)'(N);
         w_idx = w_sum[PTR_W-1:0];
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of result sources into the register
// file write port, plus a busy scoreboard guarding against WAW hazards at issue.
module wb_scheduler
   import wb_scheduler_pkg::*;
#(
   parameter int NUM_SRC = 3
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_SRC-1:0]           src_valid,
   output logic [NUM_SRC-1:0]           src_ready,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] src_rd,
   input  logic [NUM_SRC*XLEN-1:0]      src_data,
   output logic                         rf_write_enable,
   output logic [REG_ADDR_W-1:0]        rf_rd_address,
   output logic [XLEN-1:0]              rf_rd_data,
   input  logic                         issue_valid,
   input  logic [REG_ADDR_W-1:0]        issue_rd,
   output logic                         issue_ready,
   input  logic [REG_ADDR_W-1:0]        query_rs1,
   input  logic [REG_ADDR_W-1:0]        query_rs2,
   output logic                         rs1_busy,
   output logic                         rs2_busy,
   output logic [NUM_REGS-1:0]          busy
);

   localparam int PTR_W = $clog2(NUM_SRC);

   logic [PTR_W-1:0]      r_rr_ptr;
   logic                  r_we;
   logic [REG_ADDR_W-1:0] r_addr;
   logic [XLEN-1:0]       r_data;
   logic [NUM_REGS-1:0]   r_busy;

   logic [NUM_SRC-1:0]    w_grant;
   logic                  w_xfer;
   logic [PTR_W-1:0]      w_gnt_idx;
   logic [PTR_W-1:0]      w_ptr_next;
   logic [REG_ADDR_W-1:0] w_sel_rd;
   logic [XLEN-1:0]       w_sel_data;
   logic                  w_issue_set;
   logic [NUM_REGS-1:0]   w_busy_next;

   rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_arb (
      .i_req   (src_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant)
   );

   assign src_ready = reset ? '0 : w_grant;
   assign w_xfer    = |(src_valid & src_ready);

   // Grant is one-hot, so OR-reduction of the masked fields is the mux.
   always_comb begin
      w_gnt_idx  = '0;
      w_sel_rd   = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_grant[i]) begin
            w_gnt_idx  = PTR_W'(i);
            w_sel_rd   = w_sel_rd | src_rd[i*REG_ADDR_W +: REG_ADDR_W];
            w_sel_data = w_sel_data | src_data[i*XLEN +: XLEN];
         end
      end
   end

   assign w_ptr_next = (w_gnt_idx == PTR_W'(NUM_SRC-1)) ? '0 : w_gnt_idx + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rr_ptr <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
      end else begin
         r_we <= w_xfer;
         if (w_xfer) begin
            r_rr_ptr <= w_ptr_next;
            r_addr   <= w_sel_rd;
            r_data   <= w_sel_data;
         end
      end
   end

   assign rf_write_enable = r_we;
   assign rf_rd_address   = r_addr;
   assign rf_rd_data      = r_data;

   assign issue_ready = reset ? 1'b0 : ~r_busy[issue_rd];
   assign w_issue_set = issue_valid & issue_ready & (issue_rd != '0);

   // Clear on commit first so a same-register issue in the same cycle wins.
   always_comb begin
      w_busy_next = r_busy;
      if (r_we)
         w_busy_next[r_addr] = 1'b0;
      if (w_issue_set)
         w_busy_next[issue_rd] = 1'b1;
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_busy <= '0;
      else
         r_busy <= w_busy_next;
   end

   assign busy     = r_busy;
   assign rs1_busy = r_busy[query_rs1];
   assign rs2_busy = r_busy[query_rs2];

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed bench for wb_scheduler: arbitration order, writeback latency, scoreboard, reset.
module tb_wb_scheduler;

   logic        clock;
   logic        reset;
   logic [2:0]  src_valid;
   logic [2:0]  src_ready;
   logic [14:0] src_rd;
   logic [95:0] src_data;
   logic        rf_write_enable;
   logic [4:0]  rf_rd_address;
   logic [31:0] rf_rd_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [4:0]  query_rs1;
   logic [4:0]  query_rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic [31:0] busy;

   int total  = 0;
   int passed = 0;

   wb_scheduler #(.NUM_SRC(3)) dut (
      .clock           (clock),
      .reset           (reset),
      .src_valid       (src_valid),
      .src_ready       (src_ready),
      .src_rd          (src_rd),
      .src_data        (src_data),
      .rf_write_enable (rf_write_enable),
      .rf_rd_address   (rf_rd_address),
      .rf_rd_data      (rf_rd_data),
      .issue_valid     (issue_valid),
      .issue_rd        (issue_rd),
      .issue_ready     (issue_ready),
      .query_rs1       (query_rs1),
      .query_rs2       (query_rs2),
      .rs1_busy        (rs1_busy),
      .rs2_busy        (rs2_busy),
      .busy            (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
         $display("check %s obs=%h exp=%h", tag, obs, exp);
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] data);
      src_rd[i*5 +: 5]    = rd;
      src_data[i*32 +: 32] = data;
   endtask

   initial begin
      reset       = 1'b1;
      src_valid   = 3'b111;
      src_rd      = '0;
      src_data    = '0;
      issue_valid = 1'b1;
      issue_rd    = 5'd1;
      query_rs1   = 5'd0;
      query_rs2   = 5'd0;
      #2;
      chk("rst_src_ready",   32'(src_ready), 32'h0);
      chk("rst_issue_ready", 32'(issue_ready), 32'h0);
      chk("rst_we",          32'(rf_write_enable), 32'h0);
      chk("rst_addr",        32'(rf_rd_address), 32'h0);
      chk("rst_data",        rf_rd_data, 32'h0);
      chk("rst_busy",        busy, 32'h0);
      issue_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Contention: all three sources valid from reset.
      set_src(0, 5'd10, 32'hA000_0000);
      set_src(1, 5'd11, 32'hA000_0001);
      set_src(2, 5'd12, 32'hA000_0002);
      #1;
      chk("cont_g0", 32'(src_ready), 32'h1);
      tick();
      chk("cont_we1",   32'(rf_write_enable), 32'h1);
      chk("cont_addr1", 32'(rf_rd_address), 32'd10);
      chk("cont_data1", rf_rd_data, 32'hA000_0000);
      chk("cont_g1",    32'(src_ready), 32'h2);
      tick();
      chk("cont_addr2", 32'(rf_rd_address), 32'd11);
      chk("cont_data2", rf_rd_data, 32'hA000_0001);
      chk("cont_g2",    32'(src_ready), 32'h4);
      tick();
      chk("cont_we3",   32'(rf_write_enable), 32'h1);
      chk("cont_addr3", 32'(rf_rd_address), 32'd12);
      chk("cont_data3", rf_rd_data, 32'hA000_0002);
      src_valid = 3'b000;
      #1;
      chk("idle_ready", 32'(src_ready), 32'h0);
      tick();
      chk("idle_we",   32'(rf_write_enable), 32'h0);
      chk("hold_addr", 32'(rf_rd_address), 32'd12);
      chk("hold_data", rf_rd_data, 32'hA000_0002);

      // Single source, pointer at 0.
      src_valid = 3'b001;
      set_src(0, 5'd5, 32'hDEAD_BEEF);
      #1;
      chk("single_ready", 32'(src_ready), 32'h1);
      tick();
      src_valid = 3'b000;
      chk("single_we",   32'(rf_write_enable), 32'h1);
      chk("single_addr", 32'(rf_rd_address), 32'd5);
      chk("single_data", rf_rd_data, 32'hDEAD_BEEF);

      // Pointer at 1 with sources 0 and 2 valid: source 2 wins; it carries rd=0.
      src_valid = 3'b101;
      set_src(0, 5'd20, 32'h0000_0055);
      set_src(2, 5'd0,  32'h1234_5678);
      #1;
      chk("rr_skip_ready", 32'(src_ready), 32'h4);
      tick();
      chk("x0_we",   32'(rf_write_enable), 32'h1);
      chk("x0_addr", 32'(rf_rd_address), 32'd0);
      chk("x0_data", rf_rd_data, 32'h1234_5678);
      chk("rr_wrap_ready", 32'(src_ready), 32'h1);
      tick();
      src_valid = 3'b000;
      chk("wrap_addr", 32'(rf_rd_address), 32'd20);
      chk("x0_busy",   busy, 32'h0);

      // Scoreboard: reserve r7, query, WAW block, writeback clears.
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      #1;
      chk("iss7_ready", 32'(issue_ready), 32'h1);
      tick();
      query_rs1 = 5'd7;
      query_rs2 = 5'd6;
      #1;
      chk("busy7",      busy, 32'h0000_0080);
      chk("rs1_busy7",  32'(rs1_busy), 32'h1);
      chk("rs2_busy6",  32'(rs2_busy), 32'h0);
      chk("waw_ready",  32'(issue_ready), 32'h0);
      issue_rd = 5'd0;
      #1;
      chk("iss0_ready", 32'(issue_ready), 32'h1);
      tick();
      issue_valid = 1'b0;
      chk("iss0_busy", busy, 32'h0000_0080);
      src_valid = 3'b010;
      set_src(1, 5'd7, 32'h7777_7777);
      #1;
      chk("wb7_ready", 32'(src_ready), 32'h2);
      tick();
      src_valid = 3'b000;
      chk("wb7_we",       32'(rf_write_enable), 32'h1);
      chk("wb7_addr",     32'(rf_rd_address), 32'd7);
      chk("busy7_commit", busy, 32'h0000_0080);
      tick();
      chk("busy7_clear", busy, 32'h0);
      chk("rs1_clear",   32'(rs1_busy), 32'h0);

      // Same-register set and clear: commit r3 (not busy) while issuing r3.
      src_valid = 3'b100;
      set_src(2, 5'd3, 32'h3333_3333);
      #1;
      chk("wb3_ready", 32'(src_ready), 32'h4);
      tick();
      src_valid   = 3'b000;
      issue_valid = 1'b1;
      issue_rd    = 5'd3;
      #1;
      chk("wb3_we",      32'(rf_write_enable), 32'h1);
      chk("iss3_ready",  32'(issue_ready), 32'h1);
      tick();
      issue_rd = 5'd4;
      #1;
      chk("set_wins3", busy, 32'h0000_0008);
      tick();
      issue_valid = 1'b0;
      chk("busy34", busy, 32'h0000_0018);

      // Different registers: commit r4 while issuing r9.
      src_valid = 3'b001;
      set_src(0, 5'd4, 32'h4444_4444);
      #1;
      chk("wb4_ready", 32'(src_ready), 32'h1);
      tick();
      src_valid   = 3'b000;
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      #1;
      chk("wb4_addr", 32'(rf_rd_address), 32'd4);
      tick();
      issue_valid = 1'b0;
      chk("set_clear_diff", busy, 32'h0000_0208);

      // Reset the cycle after a transfer.
      src_valid = 3'b010;
      set_src(1, 5'd15, 32'hF0F0_F0F0);
      #1;
      chk("pre_rst_ready", 32'(src_ready), 32'h2);
      tick();
      chk("pre_rst_we", 32'(rf_write_enable), 32'h1);
      reset     = 1'b1;
      src_valid = 3'b110;
      #1;
      chk("mid_rst_we",    32'(rf_write_enable), 32'h0);
      chk("mid_rst_busy",  busy, 32'h0);
      chk("mid_rst_addr",  32'(rf_rd_address), 32'h0);
      chk("mid_rst_ready", 32'(src_ready), 32'h0);
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_grant", 32'(src_ready), 32'h2);
      chk("post_rst_we",    32'(rf_write_enable), 32'h0);
      tick();
      src_valid = 3'b000;
      chk("post_rst_addr", 32'(rf_rd_address), 32'd15);
      chk("post_rst_we1",  32'(rf_write_enable), 32'h1);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
